// File: rtl/regfile_banked_if.sv
// regfile_banked_if: write, read and clear-request signals of the banked register file.
// The master modport belongs to the datapath side; the slave modport belongs to the register file.
interface regfile_banked_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BANK_W = 1
);
  logic              WrEn;
  logic [BANK_W-1:0] WrBank;
  logic [ADDR_W-1:0] WrAddr;
  logic [WIDTH-1:0]  WrData;
  logic [BANK_W-1:0] RdBank1;
  logic [BANK_W-1:0] RdBank2;
  logic [ADDR_W-1:0] ReadAddr1;
  logic [ADDR_W-1:0] ReadAddr2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic              ClrReq;
  logic [BANK_W-1:0] ClrBank;
  logic              Busy;

  modport master (
    output WrEn, WrBank, WrAddr, WrData,
    output RdBank1, RdBank2, ReadAddr1, ReadAddr2,
    output ClrReq, ClrBank,
    input  ReadData1, ReadData2, Busy
  );

  modport slave (
    input  WrEn, WrBank, WrAddr, WrData,
    input  RdBank1, RdBank2, ReadAddr1, ReadAddr2,
    input  ClrReq, ClrBank,
    output ReadData1, ReadData2, Busy
  );
endinterface

// File: rtl/regfile_banked.sv
// regfile_banked: multi-bank register file with one write port, two combinational read ports,
// and a one-entry-per-cycle clear engine that zeroes all banks or one bank.
// All state changes on the falling edge of clk. rst is synchronous and active-high.
// Optional macro REGFILE_BYPASS_EN forwards write data to a read port that matches in the same cycle.
//
// state    | meaning
// IDLE     | writes and clear requests are accepted
// CLR_ALL  | entry cnt is zeroed in every bank on each edge (entered from reset)
// CLR_BANK | entry cnt of bank tbank is zeroed on each edge
module regfile_banked #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BANKS  = 2,
  parameter int BANK_W = 1
) (
  input logic             clk,
  input logic             rst,
  regfile_banked_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  // BANKS held one bit wider than a bank select, so that BANKS == 2**BANK_W can still be compared.
  localparam logic [BANK_W:0] NBANK = (BANK_W + 1)'(BANKS);

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_BANK} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [BANK_W-1:0] tbank;
  logic              busy;
  logic [WIDTH-1:0]  mem [BANKS][DEPTH];

  logic wr_ok;
  logic clr_ok;

  assign wr_ok  = bus.WrEn   && ({1'b0, bus.WrBank}  < NBANK);
  assign clr_ok = bus.ClrReq && ({1'b0, bus.ClrBank} < NBANK);

  // Sequencing FSM; also updates the sweep counter, the target bank and the registered Busy.
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= CLR_ALL;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_ok) begin
            state <= CLR_BANK;
            tbank <= bus.ClrBank;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLR_ALL, CLR_BANK: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: sweep clears take priority, and writes are accepted only in IDLE.
  always_ff @(negedge clk) begin
    if (!rst) begin
      if (state == CLR_ALL) begin
        for (int b = 0; b < BANKS; b++) mem[b][cnt] <= '0;
      end else if (state == CLR_BANK) begin
        mem[tbank][cnt] <= '0;
      end else if (wr_ok) begin
        mem[bus.WrBank][bus.WrAddr] <= bus.WrData;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [BANK_W-1:0] b,
                                                 input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] d;
    d = '0;
    if (!busy && ({1'b0, b} < NBANK)) begin
      d = mem[b][a];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (b == bus.WrBank) && (a == bus.WrAddr)) d = bus.WrData;
`endif
    end
    return d;
  endfunction

  // Combinational read ports; a port reads zero while a sweep runs or when its bank is out of range.
  always_comb begin
    bus.ReadData1 = read_port(bus.RdBank1, bus.ReadAddr1);
    bus.ReadData2 = read_port(bus.RdBank2, bus.ReadAddr2);
  end

  assign bus.Busy = busy;
endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: directed bench for regfile_banked with a default two-bank instance
// and a three-bank instance (BANK_W=2) for out-of-range bank selects.
module tb_regfile_banked;
  logic clk;
  logic rst;

  regfile_banked_if #(.WIDTH(32), .ADDR_W(5), .BANK_W(1)) ifa ();
  regfile_banked_if #(.WIDTH(32), .ADDR_W(5), .BANK_W(2)) ifb ();

  regfile_banked #(.WIDTH(32), .ADDR_W(5), .BANKS(2), .BANK_W(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  regfile_banked #(.WIDTH(32), .ADDR_W(5), .BANKS(3), .BANK_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          total = 0;
  int          npass = 0;
  logic [31:0] mdl [2][32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t s;
    if (sbq.size() == 0) begin
      total++;
      $error("FAIL sb_empty: observed %h expected none", obs);
    end else begin
      s = sbq.pop_front();
      chk(s.tag, obs, s.exp);
    end
  endtask

  // Active edge is the falling edge; drive and sample 1 time unit after it.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rd_a(input logic b1, input logic [4:0] a1, input logic b2, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2, input string tag);
    sb_push({tag, "_p1"}, e1);
    sb_push({tag, "_p2"}, e2);
    ifa.RdBank1 = b1; ifa.ReadAddr1 = a1;
    ifa.RdBank2 = b2; ifa.ReadAddr2 = a2;
    #1;
    sb_check(ifa.ReadData1);
    sb_check(ifa.ReadData2);
  endtask

  task automatic rd_m(input logic b1, input logic [4:0] a1, input logic b2, input logic [4:0] a2,
                      input string tag);
    rd_a(b1, a1, b2, a2, mdl[b1][a1], mdl[b2][a2], tag);
  endtask

  task automatic rd_b(input logic [1:0] b1, input logic [1:0] b2, input logic [4:0] a,
                      input logic [31:0] e1, input logic [31:0] e2, input string tag);
    sb_push({tag, "_p1"}, e1);
    sb_push({tag, "_p2"}, e2);
    ifb.RdBank1 = b1; ifb.ReadAddr1 = a;
    ifb.RdBank2 = b2; ifb.ReadAddr2 = a;
    #1;
    sb_check(ifb.ReadData1);
    sb_check(ifb.ReadData2);
  endtask

  task automatic wr_a(input logic b, input logic [4:0] a, input logic [31:0] d);
    ifa.WrEn = 1'b1; ifa.WrBank = b; ifa.WrAddr = a; ifa.WrData = d;
    step();
    ifa.WrEn = 1'b0;
    mdl[b][a] = d;
  endtask

  task automatic wait_idle_a(output int n);
    n = 0;
    while (ifa.Busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++) mdl[b][a] = 32'h0;
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 32; a++) rd_m(1'b0, 5'(a), 1'b1, 5'(a), tag);
  endtask

  initial begin
    int n;

    rst = 1'b1;
    ifa.WrEn = 1'b0; ifa.WrBank = '0; ifa.WrAddr = '0; ifa.WrData = '0;
    ifa.RdBank1 = '0; ifa.RdBank2 = '0; ifa.ReadAddr1 = '0; ifa.ReadAddr2 = '0;
    ifa.ClrReq = 1'b0; ifa.ClrBank = '0;
    ifb.WrEn = 1'b0; ifb.WrBank = '0; ifb.WrAddr = '0; ifb.WrData = '0;
    ifb.RdBank1 = '0; ifb.RdBank2 = '0; ifb.ReadAddr1 = '0; ifb.ReadAddr2 = '0;
    ifb.ClrReq = 1'b0; ifb.ClrBank = '0;
    clear_model();

    // Reset held for three edges, then released.
    step();
    chk("rst_busy", {31'h0, ifa.Busy}, 32'h1);
    rd_a(1'b0, 5'd0, 1'b1, 5'd31, 32'h0, 32'h0, "rst_rd");
    step();
    step();
    rst = 1'b0;
    wait_idle_a(n);
    chk("rst_busy_len", n, 32);
    chk("rst_b_idle", {31'h0, ifb.Busy}, 32'h0);
    check_all("after_rst");

    // Plain write and read, both ports, then both ports on one entry.
    wr_a(1'b1, 5'd7, 32'hDEADBEEF);
    wr_a(1'b0, 5'd7, 32'h12345678);
    rd_m(1'b1, 5'd7, 1'b0, 5'd7, "wr_rd");
    rd_m(1'b1, 5'd7, 1'b1, 5'd7, "same_entry");

    // Write visibility in the write cycle: forwarded with bypass, old value otherwise.
    wr_a(1'b0, 5'd3, 32'h11111111);
    ifa.WrEn = 1'b1; ifa.WrBank = 1'b0; ifa.WrAddr = 5'd3; ifa.WrData = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    rd_a(1'b0, 5'd3, 1'b1, 5'd3, 32'hA5A5A5A5, mdl[1][3], "bypass_same_cycle");
`else
    rd_a(1'b0, 5'd3, 1'b1, 5'd3, 32'h11111111, mdl[1][3], "nobypass_same_cycle");
`endif
    step();
    ifa.WrEn = 1'b0;
    mdl[0][3] = 32'hA5A5A5A5;
    rd_m(1'b0, 5'd3, 1'b1, 5'd3, "after_write_edge");

    // Fill both banks.
    for (int a = 0; a < 32; a++) begin
      wr_a(1'b0, 5'(a), 32'h10000000 | a);
      wr_a(1'b1, 5'(a), 32'h20000000 | a);
    end
    check_all("filled");

    // Clear bank 1 with a simultaneous write to bank 0; writes and requests during the sweep are dropped.
    ifa.ClrReq = 1'b1; ifa.ClrBank = 1'b1;
    ifa.WrEn = 1'b1; ifa.WrBank = 1'b0; ifa.WrAddr = 5'd5; ifa.WrData = 32'h00000055;
    step();
    ifa.ClrReq = 1'b0; ifa.WrEn = 1'b0;
    mdl[0][5] = 32'h00000055;
    for (int a = 0; a < 32; a++) mdl[1][a] = 32'h0;
    n = 0;
    while (ifa.Busy === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin
        ifa.WrEn = 1'b1; ifa.WrBank = 1'b1; ifa.WrAddr = 5'd2; ifa.WrData = 32'hFFFFFFFF;
        ifa.ClrReq = 1'b1; ifa.ClrBank = 1'b0;
      end
      if (n == 6) begin
        ifa.WrEn = 1'b0; ifa.ClrReq = 1'b0;
      end
      if (n == 10) rd_a(1'b0, 5'd1, 1'b1, 5'd20, 32'h0, 32'h0, "rd_during_sweep");
      step();
    end
    chk("clr_busy_len", n, 32);
    check_all("after_bank_clr");

    // Reset at cnt=10 of a bank-0 clear restarts as a full clear from entry 0.
    ifa.ClrReq = 1'b1; ifa.ClrBank = 1'b0;
    step();
    ifa.ClrReq = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("midsweep_rst_busy", {31'h0, ifa.Busy}, 32'h1);
    rst = 1'b0;
    wait_idle_a(n);
    chk("midsweep_rst_len", n, 32);
    clear_model();
    check_all("after_midsweep_rst");

    // Three-bank instance: bank 3 is out of range for writes, reads and clears.
    ifb.WrEn = 1'b1; ifb.WrBank = 2'd2; ifb.WrAddr = 5'd4; ifb.WrData = 32'h00000077;
    step();
    ifb.WrBank = 2'd3; ifb.WrData = 32'h00000099;
    step();
    ifb.WrEn = 1'b0;
    rd_b(2'd3, 2'd2, 5'd4, 32'h0, 32'h00000077, "oor_rd_b3_b2");
    rd_b(2'd0, 2'd1, 5'd4, 32'h0, 32'h0, "oor_rd_b0_b1");
    ifb.ClrReq = 1'b1; ifb.ClrBank = 2'd3;
    step();
    ifb.ClrReq = 1'b0;
    chk("oor_clr_ignored", {31'h0, ifb.Busy}, 32'h0);
    rd_b(2'd2, 2'd3, 5'd4, 32'h00000077, 32'h0, "oor_after_clr");
    ifb.ClrReq = 1'b1; ifb.ClrBank = 2'd2;
    step();
    ifb.ClrReq = 1'b0;
    n = 0;
    while (ifb.Busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk("b_clr_busy_len", n, 32);
    rd_b(2'd2, 2'd0, 5'd4, 32'h0, 32'h0, "b_after_clr");

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
